// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU writeback stage with status register and 2-entry skid buffer.
// Optional STATUS_STICKY_OV_EN adds ov_clr/ov_sticky sticky overflow tracking.
module alu_wb_stage #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 4,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [3:0]        alu_mode,
  input  logic [REG_AW-1:0] in_dst,
  input  logic              in_we,
  input  logic              flag_we,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_addr,
  output logic [FLAG_W-1:0] status,
`ifdef STATUS_STICKY_OV_EN
  input  logic              ov_clr,
  output logic              ov_sticky,
`endif
  output logic              busy
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  localparam logic [FLAG_W-1:0] C_MASK = FLAG_W'(4);
  state_t state, state_n;
  logic [DATA_W-1:0] skid_data;
  logic [REG_AW-1:0] skid_addr;
  logic accept, push, drain, arith, upd, load_in, load_skid, skid_to_head;
  logic [FLAG_W-1:0] status_n;
  assign in_ready = state != FULL;
  assign wb_valid = state != EMPTY;
  assign busy = wb_valid;
  assign accept = in_valid & in_ready;
  assign push = accept & in_we;
  assign drain = wb_valid & wb_ready;
  assign upd = accept & flag_we;
  // Arithmetic modes share low bits 000, 001 or 111 regardless of the top bit
  assign arith = alu_mode[2:0] == 3'b000 || alu_mode[2:0] == 3'b001 || alu_mode[2:0] == 3'b111;
  assign status_n = arith ? alu_flags : (alu_flags & ~C_MASK) | (status & C_MASK);
  always_comb begin
    state_n = state;
    load_in = 1'b0;
    load_skid = 1'b0;
    skid_to_head = 1'b0;
    case (state)
      EMPTY: begin
        state_n = push ? ONE : EMPTY;
        load_in = push;
      end
      ONE: begin
        state_n = push && !drain ? FULL : !push && drain ? EMPTY : ONE;
        load_in = push & drain;
        load_skid = push & ~drain;
      end
      FULL: begin
        state_n = drain ? ONE : FULL;
        skid_to_head = drain;
      end
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      wb_data <= '0;
      wb_addr <= '0;
      skid_data <= '0;
      skid_addr <= '0;
      status <= '0;
    end else begin
      state <= state_n;
      if (load_in) begin
        wb_data <= alu_out;
        wb_addr <= in_dst;
      end else if (skid_to_head) begin
        wb_data <= skid_data;
        wb_addr <= skid_addr;
      end
      if (load_skid) begin
        skid_data <= alu_out;
        skid_addr <= in_dst;
      end
      if (upd) status <= status_n;
    end
  end
`ifdef STATUS_STICKY_OV_EN
  always_ff @(posedge clk) begin
    if (rst) ov_sticky <= 1'b0;
    else ov_sticky <= (upd & status_n[0]) ? 1'b1 : ov_clr ? 1'b0 : ov_sticky;
  end
`endif
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed self-checking bench for alu_wb_stage.
module tb_alu_wb_stage;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_we = 0, flag_we = 0, wb_valid, wb_ready = 0, busy;
  logic [7:0] alu_out = 0, wb_data;
  logic [3:0] alu_flags = 0, alu_mode = 0, status;
  logic [2:0] in_dst = 0, wb_addr;
`ifdef STATUS_STICKY_OV_EN
  logic ov_clr = 0, ov_sticky;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_flags(alu_flags), .alu_mode(alu_mode),
    .in_dst(in_dst), .in_we(in_we), .flag_we(flag_we),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_addr(wb_addr), .status(status),
`ifdef STATUS_STICKY_OV_EN
    .ov_clr(ov_clr), .ov_sticky(ov_sticky),
`endif
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic we, input logic fwe, input logic [3:0] m,
                     input logic [3:0] f, input logic [7:0] d, input logic [2:0] a);
    in_valid = v; in_we = we; flag_we = fwe; alu_mode = m; alu_flags = f;
    alu_out = d; in_dst = a;
  endtask
  initial begin
    tick;
    chk("rst_valid", wb_valid, 0); chk("rst_data", wb_data, 0); chk("rst_addr", wb_addr, 0);
    chk("rst_status", status, 0); chk("rst_ready", in_ready, 1); chk("rst_busy", busy, 0);
    rst = 0;
    wb_ready = 1;
    drv(1, 1, 1, 4'b0000, 4'b0000, 8'h5A, 3); tick;
    chk("t1_valid", wb_valid, 1); chk("t1_data", wb_data, 8'h5A); chk("t1_addr", wb_addr, 3);
    drv(0, 0, 0, 0, 0, 0, 0); tick;
    chk("t1_empty", wb_valid, 0); chk("t1_busy", busy, 0);
    wb_ready = 0;
    drv(1, 1, 0, 0, 0, 8'h11, 1); tick;
    chk("t2_v1", wb_valid, 1); chk("t2_rdy1", in_ready, 1);
    drv(1, 1, 0, 0, 0, 8'h22, 2); tick;
    chk("t2_full", in_ready, 0); chk("t2_head", wb_data, 8'h11);
    drv(1, 1, 0, 0, 0, 8'h33, 5); tick;
    chk("t2_hold_rdy", in_ready, 0); chk("t2_hold_data", wb_data, 8'h11); chk("t2_hold_addr", wb_addr, 1);
    wb_ready = 1; tick;
    chk("t2_d2", wb_data, 8'h22); chk("t2_a2", wb_addr, 2); chk("t2_rdy2", in_ready, 1);
    tick;
    chk("t2_d3", wb_data, 8'h33); chk("t2_a3", wb_addr, 5); chk("t2_v3", wb_valid, 1);
    drv(0, 0, 0, 0, 0, 0, 0); tick;
    chk("t2_drained", wb_valid, 0); chk("t2_status", status, 0);
    drv(1, 0, 1, 4'b0000, 4'b0100, 8'hEE, 7); tick;
    chk("t3_s1", status, 4'b0100); chk("t3_nowb", wb_valid, 0);
    drv(1, 0, 1, 4'b0100, 4'b1001, 0, 0); tick;
    chk("t3_ckeep", status, 4'b1101);
    drv(1, 0, 1, 4'b1111, 4'b0001, 0, 0); tick;
    chk("t3_arith15", status, 4'b0001);
    drv(1, 0, 1, 4'b0010, 4'b0100, 0, 0); tick;
    chk("t3_cignore", status, 4'b0000);
    drv(1, 0, 1, 4'b0001, 4'b1000, 0, 0); tick;
    chk("t4_status", status, 4'b1000); chk("t4_nowb", wb_valid, 0);
    drv(1, 0, 0, 4'b0000, 4'b0110, 0, 0); tick;
    chk("fwe0_hold", status, 4'b1000);
    drv(0, 0, 1, 4'b0000, 4'b0110, 0, 0); tick;
    chk("nov_hold", status, 4'b1000);
    wb_ready = 0;
    drv(1, 1, 1, 4'b0000, 4'b0110, 8'hA1, 4); tick;
    drv(1, 1, 1, 4'b0000, 4'b0110, 8'hA2, 6); tick;
    chk("t5_full", in_ready, 0); chk("t5_status", status, 4'b0110); chk("t5_busy", busy, 1);
    rst = 1; tick;
    chk("t5_valid", wb_valid, 0); chk("t5_st0", status, 0); chk("t5_rdy", in_ready, 1);
    chk("t5_data", wb_data, 0);
    rst = 0; drv(0, 0, 0, 0, 0, 0, 0); tick;
    chk("t5_idle", busy, 0);
`ifdef STATUS_STICKY_OV_EN
    chk("t6_rst", ov_sticky, 0);
    drv(1, 0, 1, 4'b0000, 4'b0001, 0, 0); tick;
    chk("t6_set", ov_sticky, 1);
    drv(1, 0, 1, 4'b0000, 4'b0000, 0, 0); tick;
    chk("t6_keep", ov_sticky, 1); chk("t6_status", status, 0);
    drv(0, 0, 0, 0, 0, 0, 0); ov_clr = 1; tick;
    chk("t6_clr", ov_sticky, 0);
    drv(1, 0, 1, 4'b0100, 4'b0001, 0, 0); tick;
    chk("t6_setwins", ov_sticky, 1);
    ov_clr = 0; drv(0, 0, 0, 0, 0, 0, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
